// File: rtl/chip_magcomp_checker.sv
// chip_magcomp_checker: drives A/B/cascade vectors into 7485-style comparator chips and checks GT/EQ/LT
module chip_magcomp_checker #(
  parameter int          WIDTH         = 4,
  parameter int          SETTLE_CYCLES = 4,
  parameter int          NUM_SAMPLES   = 256,
  parameter logic [63:0] LFSR_SEED     = 64'h1,
  parameter int          CNT_W         = 16,
  parameter bit          STOP_ON_FAIL  = 1'b0
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Run,
  input  logic                 Mode,
  input  logic                 DISP_RSLT,
  output logic [WIDTH-1:0]     A_out,
  output logic [WIDTH-1:0]     B_out,
  output logic [2:0]           Casc_out,
  input  logic                 Gt_in,
  input  logic                 Eq_in,
  input  logic                 Lt_in,
  output logic                 Busy,
  output logic                 Done,
  output logic                 RSLT,
  output logic [CNT_W-1:0]     Fail_count,
  output logic                 Fail_valid,
  output logic [2*WIDTH+1:0]   First_fail
);
  localparam int AB_W = 2 * WIDTH;
  localparam int SC_W = $clog2(SETTLE_CYCLES + 1);
  localparam int N_W  = $clog2(NUM_SAMPLES + 1);
  localparam logic [SC_W-1:0] SETTLE_LAST = SC_W'(SETTLE_CYCLES - 1);
  localparam logic [N_W-1:0]  N_LAST      = N_W'(NUM_SAMPLES - 1);
  // Galois feedback masks for maximal-length sequences of the common widths
  localparam logic [63:0] TAPS_64 = AB_W == 8  ? 64'hB8 :
                                    AB_W == 16 ? 64'hB400 :
                                    AB_W == 24 ? 64'hE10000 :
                                    AB_W == 32 ? 64'hA3000000 :
                                    (64'h1 << (AB_W - 1)) | 64'h1;
  localparam logic [AB_W-1:0] TAPS = TAPS_64[AB_W-1:0];
  typedef enum logic [2:0] {IDLE, APPLY, SETTLE, SAMPLE, DONE} state_t;
  state_t state, state_nx;
  logic run_q, mode_q, pass;
  logic [1:0] gt_s, eq_s, lt_s;
  logic [AB_W-1:0] ab;
  logic [1:0] casc_idx;
  logic [SC_W-1:0] cnt;
  logic [N_W-1:0] n;
  logic start, mismatch, last;
  logic [2:0] expect_v;
  assign start    = Run & ~run_q & (state == IDLE || state == DONE);
  assign expect_v = A_out > B_out ? 3'b100 : A_out < B_out ? 3'b001 : Casc_out;
  assign mismatch = {gt_s[1], eq_s[1], lt_s[1]} != expect_v;
  assign last     = mode_q ? n == N_LAST : (&ab && casc_idx == 2'd2);
  assign Busy     = state inside {APPLY, SETTLE, SAMPLE};
  assign Done     = state == DONE;
  assign RSLT     = pass & Done & DISP_RSLT;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: state_nx = start ? APPLY : state;
      APPLY:      state_nx = SETTLE;
      SETTLE:     state_nx = cnt == SETTLE_LAST ? SAMPLE : SETTLE;
      SAMPLE:     state_nx = (last || (STOP_ON_FAIL && mismatch)) ? DONE : APPLY;
      default:    state_nx = IDLE;
    endcase
  end
  always_ff @(posedge Clk) state <= Reset ? IDLE : state_nx;
  always_ff @(posedge Clk) begin
    run_q <= Run;
    if (Reset) begin
      gt_s       <= '0;
      eq_s       <= '0;
      lt_s       <= '0;
      A_out      <= '0;
      B_out      <= '0;
      Casc_out   <= '0;
      Fail_count <= '0;
      Fail_valid <= 1'b0;
      First_fail <= '0;
      pass       <= 1'b1;
      mode_q     <= 1'b0;
      ab         <= '0;
      casc_idx   <= '0;
      cnt        <= '0;
      n          <= '0;
    end else begin
      gt_s <= {gt_s[0], Gt_in};
      eq_s <= {eq_s[0], Eq_in};
      lt_s <= {lt_s[0], Lt_in};
      if (start) begin
        Fail_count <= '0;
        Fail_valid <= 1'b0;
        First_fail <= '0;
        pass       <= 1'b1;
        mode_q     <= Mode;
        ab         <= Mode ? LFSR_SEED[AB_W-1:0] : '0;
        casc_idx   <= '0;
        n          <= '0;
      end
      if (state == APPLY) begin
        A_out    <= ab[AB_W-1:WIDTH];
        B_out    <= ab[WIDTH-1:0];
        Casc_out <= 3'b100 >> casc_idx;
        cnt      <= '0;
      end
      if (state == SETTLE) cnt <= cnt + 1'b1;
      if (state == SAMPLE) begin
        if (mismatch) begin
          pass <= 1'b0;
          if (~&Fail_count) Fail_count <= Fail_count + 1'b1;
          if (!Fail_valid) begin
            First_fail <= {A_out, B_out, casc_idx};
            Fail_valid <= 1'b1;
          end
        end
        // casc_idx is stepped after capture so First_fail records the vector just checked
        casc_idx <= casc_idx == 2'd2 ? 2'd0 : casc_idx + 1'b1;
        n        <= n + 1'b1;
        ab       <= mode_q ? (ab >> 1) ^ (ab[0] ? TAPS : '0) : (casc_idx == 2'd2 ? ab + 1'b1 : ab);
      end
    end
  end
endmodule
